// File: rtl/io_port_controller.sv
// io_port_controller: MMIO endpoint with a TX FIFO drained over valid/ready and a stalling one-word RX read path.
// Optional feature macro IO_LOOPBACK_EN adds lb_mode, which routes the FIFO head into the RX holding register.
module io_port_controller #(
  parameter int DATA_W   = 32,
  parameter int TX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] io_data_out,
  input  logic              io_write_en,
  input  logic              io_rden,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_busy,
  output logic              io_ovf,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
`ifdef IO_LOOPBACK_EN
  input  logic              lb_mode,
`endif
  output logic              rx_ready
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(TX_DEPTH);
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DONE} rstate_e;
  rstate_e           state_q, state_d;
  logic [DATA_W-1:0] mem_q [TX_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] rx_buf_q, rdata_d, cap_data;
  logic              rx_full_q, rx_full_d, busy_d, ovf_d;
  logic              lb, head_valid, push, pop, cap, load;
`ifdef IO_LOOPBACK_EN
  assign lb = lb_mode;
`else
  assign lb = 1'b0;
`endif
  assign head_valid = count_q != '0;
  // Fullness is judged on the pre-pop count, so a write into a full FIFO drops even if a pop happens too.
  assign push       = io_write_en && count_q != FULL;
  assign pop        = head_valid && (lb ? !rx_full_q : tx_ready);
  assign count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
  assign ovf_d      = io_ovf || (io_write_en && count_q == FULL);
  assign tx_data    = head_valid ? mem_q[rd_ptr_q] : '0;
  assign tx_valid   = head_valid && !lb;
  assign rx_ready   = !rx_full_q && !lb;
  assign cap        = lb ? pop : rx_valid && !rx_full_q;
  assign cap_data   = lb ? tx_data : rx_data;
  always_comb begin
    load      = rx_full_q && (state_q == R_WAIT || (state_q == R_IDLE && io_rden));
    state_d   = load ? R_DONE :
                (state_q == R_IDLE && io_rden) ? R_WAIT :
                (state_q == R_DONE) ? R_IDLE : state_q;
    rx_full_d = cap || (rx_full_q && !load);
    rdata_d   = load ? rx_buf_q : io_rdata;
    busy_d    = count_d == FULL || state_d == R_WAIT;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= R_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rx_buf_q  <= '0;
      rx_full_q <= 1'b0;
      io_rdata  <= '0;
      io_busy   <= 1'b0;
      io_ovf    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q  <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_q   <= count_d;
      rx_buf_q  <= cap ? cap_data : rx_buf_q;
      rx_full_q <= rx_full_d;
      io_rdata  <= rdata_d;
      io_busy   <= busy_d;
      io_ovf    <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= io_data_out;
  end
endmodule

// File: tb/tb_io_port_controller.sv
// tb_io_port_controller: table-driven FIFO vectors, hand-written read/reset sequences, and a queue-based random model.
module tb_io_port_controller;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] io_data_out = '0, rx_data = '0;
  logic          io_write_en = 1'b0, io_rden = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0, lb_mode = 1'b0;
  logic [DW-1:0] io_rdata, tx_data;
  logic          io_busy, io_ovf, tx_valid, rx_ready;
  int            n_chk = 0, n_pass = 0;
  io_port_controller #(.DATA_W(DW), .TX_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .io_data_out(io_data_out), .io_write_en(io_write_en),
    .io_rden(io_rden), .io_rdata(io_rdata), .io_busy(io_busy), .io_ovf(io_ovf),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
`ifdef IO_LOOPBACK_EN
    .lb_mode(lb_mode),
`endif
    .rx_valid(rx_valid), .rx_ready(rx_ready)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic          we;
    logic [DW-1:0] d;
    logic          txr;
    logic          tv;
    logic [DW-1:0] td;
    logic          busy;
    logic          ovf;
  } vec_t;
  vec_t tbl [24];
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, " io_rdata"}, io_rdata, 0);
    chk({tag, " io_busy"}, {31'b0, io_busy}, 0);
    chk({tag, " io_ovf"}, {31'b0, io_ovf}, 0);
    chk({tag, " tx_valid"}, {31'b0, tx_valid}, 0);
    chk({tag, " tx_data"}, tx_data, 0);
    chk({tag, " rx_ready"}, {31'b0, rx_ready}, 1);
  endtask
  task automatic idle_inputs();
    io_write_en = 0; io_rden = 0; tx_ready = 0; rx_valid = 0; io_data_out = '0; rx_data = '0;
  endtask
  // reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] rval, mrd, exp_td;
  bit            movf, rhas, pend, cool;
  initial begin
    tbl = '{
      '{1'b1, 32'hABCD1234, 1'b0, 1'b1, 32'hABCD1234, 1'b0, 1'b0},
      '{1'b1, 32'h00000001, 1'b0, 1'b1, 32'hABCD1234, 1'b0, 1'b0},
      '{1'b0, 32'h0,        1'b1, 1'b1, 32'h00000001, 1'b0, 1'b0},
      '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0},
      '{1'b1, 32'h10,       1'b0, 1'b1, 32'h10,       1'b0, 1'b0},
      '{1'b1, 32'h11,       1'b0, 1'b1, 32'h10,       1'b0, 1'b0},
      '{1'b1, 32'h12,       1'b0, 1'b1, 32'h10,       1'b0, 1'b0},
      '{1'b1, 32'h13,       1'b0, 1'b1, 32'h10,       1'b1, 1'b0},
      '{1'b1, 32'h14,       1'b0, 1'b1, 32'h10,       1'b1, 1'b1},
      '{1'b0, 32'h0,        1'b1, 1'b1, 32'h11,       1'b0, 1'b1},
      '{1'b0, 32'h0,        1'b1, 1'b1, 32'h12,       1'b0, 1'b1},
      '{1'b0, 32'h0,        1'b1, 1'b1, 32'h13,       1'b0, 1'b1},
      '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1},
      '{1'b1, 32'h20,       1'b0, 1'b1, 32'h20,       1'b0, 1'b1},
      '{1'b1, 32'h21,       1'b0, 1'b1, 32'h20,       1'b0, 1'b1},
      '{1'b1, 32'h22,       1'b0, 1'b1, 32'h20,       1'b0, 1'b1},
      '{1'b1, 32'h23,       1'b0, 1'b1, 32'h20,       1'b1, 1'b1},
      '{1'b1, 32'h24,       1'b1, 1'b1, 32'h21,       1'b0, 1'b1},
      '{1'b0, 32'h0,        1'b1, 1'b1, 32'h22,       1'b0, 1'b1},
      '{1'b0, 32'h0,        1'b1, 1'b1, 32'h23,       1'b0, 1'b1},
      '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1},
      '{1'b1, 32'h30,       1'b0, 1'b1, 32'h30,       1'b0, 1'b1},
      '{1'b1, 32'h31,       1'b1, 1'b1, 32'h31,       1'b0, 1'b1},
      '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1}
    };
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    @(negedge clk) reset = 0;
    step();
    for (int i = 0; i < 24; i++) begin
      io_write_en = tbl[i].we; io_data_out = tbl[i].d; tx_ready = tbl[i].txr;
      step();
      chk($sformatf("vec%0d tx_valid", i), {31'b0, tx_valid}, {31'b0, tbl[i].tv});
      chk($sformatf("vec%0d tx_data", i), tx_data, tbl[i].td);
      chk($sformatf("vec%0d io_busy", i), {31'b0, io_busy}, {31'b0, tbl[i].busy});
      chk($sformatf("vec%0d io_ovf", i), {31'b0, io_ovf}, {31'b0, tbl[i].ovf});
    end
    // fill FIFO so busy is high, then reset asynchronously mid-cycle
    for (int i = 0; i < DEPTH; i++) begin
      io_write_en = 1; io_data_out = 32'h40 + i; tx_ready = 0;
      step();
    end
    idle_inputs();
    chk("prereset busy", {31'b0, io_busy}, 1);
    #2 reset = 1;
    #1 chk_reset_outputs("async");
    @(negedge clk) reset = 0;
    step();
    chk("post reset tx_valid", {31'b0, tx_valid}, 0);
    // stalled read
    io_rden = 1;
    step();
    io_rden = 0;
    chk("stall busy N", {31'b0, io_busy}, 1);
    step();
    chk("stall busy N+1", {31'b0, io_busy}, 1);
    chk("stall rdata held", io_rdata, 0);
    rx_valid = 1; rx_data = 32'h87654321;
    step();
    rx_valid = 0; rx_data = '0;
    chk("stall busy M", {31'b0, io_busy}, 1);
    chk("stall rx_ready M", {31'b0, rx_ready}, 0);
    step();
    chk("stall rdata M+1", io_rdata, 32'h87654321);
    chk("stall busy M+1", {31'b0, io_busy}, 0);
    chk("stall rx_ready M+1", {31'b0, rx_ready}, 1);
    // fast read concurrent with a write; a second rx word is refused while full
    rx_valid = 1; rx_data = 32'hDEADBEEF;
    step();
    rx_data = 32'h11111111;
    step();
    chk("full rx_ready", {31'b0, rx_ready}, 0);
    rx_valid = 0;
    io_rden = 1; io_write_en = 1; io_data_out = 32'h5A5A5A5A;
    step();
    idle_inputs();
    chk("fast rdata", io_rdata, 32'hDEADBEEF);
    chk("fast busy", {31'b0, io_busy}, 0);
    chk("fast tx_data", tx_data, 32'h5A5A5A5A);
    chk("fast tx_valid", {31'b0, tx_valid}, 1);
    tx_ready = 1;
    step();
    tx_ready = 0;
    chk("fast drained", {31'b0, tx_valid}, 0);
`ifdef IO_LOOPBACK_EN
    lb_mode = 1; io_write_en = 1; io_data_out = 32'h12345678;
    step();
    io_write_en = 0;
    chk("lb tx_valid 0", {31'b0, tx_valid}, 0);
    chk("lb rx_ready 0", {31'b0, rx_ready}, 0);
    step();
    chk("lb tx_valid 1", {31'b0, tx_valid}, 0);
    io_rden = 1;
    step();
    io_rden = 0;
    chk("lb rdata", io_rdata, 32'h12345678);
    chk("lb busy", {31'b0, io_busy}, 0);
    chk("lb tx_valid 2", {31'b0, tx_valid}, 0);
    lb_mode = 0;
`endif
    // randomized run against the queue model
    idle_inputs();
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
    step();
    mq = {}; movf = 0; rhas = 0; pend = 0; cool = 0; mrd = '0; rval = '0;
    for (int c = 0; c < 400; c++) begin
      bit full, accept, serve, cap;
      io_write_en = ($urandom_range(0, 99) < 55);
      io_data_out = $urandom;
      tx_ready    = ($urandom_range(0, 99) < 40);
      io_rden     = ($urandom_range(0, 99) < 25);
      rx_valid    = ($urandom_range(0, 99) < 30);
      rx_data     = $urandom;
      full = mq.size() == DEPTH;
      if (io_write_en && full) movf = 1;
      if (mq.size() > 0 && tx_ready) void'(mq.pop_front());
      if (io_write_en && !full) mq.push_back(io_data_out);
      accept = io_rden && !pend && !cool;
      serve  = (pend || accept) && rhas;
      cap    = rx_valid && !rhas;
      if (serve) begin
        mrd = rval; rhas = 0; pend = 0; cool = 1;
      end else begin
        pend = pend || accept; cool = 0;
      end
      if (cap) begin
        rhas = 1; rval = rx_data;
      end
      step();
      exp_td = mq.size() > 0 ? mq[0] : '0;
      chk($sformatf("rnd%0d tx_valid", c), {31'b0, tx_valid}, {31'b0, mq.size() > 0});
      chk($sformatf("rnd%0d tx_data", c), tx_data, exp_td);
      chk($sformatf("rnd%0d io_busy", c), {31'b0, io_busy}, {31'b0, (mq.size() == DEPTH) || pend});
      chk($sformatf("rnd%0d io_ovf", c), {31'b0, io_ovf}, {31'b0, movf});
      chk($sformatf("rnd%0d io_rdata", c), io_rdata, mrd);
      chk($sformatf("rnd%0d rx_ready", c), {31'b0, rx_ready}, {31'b0, !rhas});
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/io_port_controller.md
# io_port_controller

Memory-mapped I/O endpoint on the `io_*` side of `ram_controller`, serving the I/O address window (`0xFFFFFFFF`). Writes from the core are queued in a small TX FIFO and drained to an external device over a valid/ready stream. Reads are served from a one-word RX holding register, with `io_busy` stalling the controller until data is available.

## Interface
Parameters:
- `DATA_W`, 32, word width of all data paths.
- `TX_DEPTH`, 4, TX FIFO depth in words; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `io_data_out`  in  DATA_W  write data from `ram_controller`.
- `io_write_en`  in  1  one-cycle write strobe.
- `io_rden`  in  1  one-cycle read strobe.
- `io_rdata`  out  DATA_W  read data, registered.
- `io_busy`  out  1  stall to `ram_controller`, registered.
- `io_ovf`  out  1  sticky flag: a write was dropped.
- `tx_data`  out  DATA_W  TX FIFO head.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_ready`  in  1  external device accepts `tx_data`.
- `rx_data`  in  DATA_W  external input word.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  RX holding register empty.
- `lb_mode`  in  1  loopback select; present only with `IO_LOOPBACK_EN`.

## Operation
- **Reset values:** `io_rdata` = 0, `io_busy` = 0, `io_ovf` = 0, `tx_valid` = 0, `tx_data` = 0, `rx_ready` = 1. The FIFO is emptied and the read FSM returns to `R_IDLE`. Reset mid-transfer discards all queued and held data.
- **TX push:** `io_write_en` with count < `TX_DEPTH`, sampled before this cycle's pop, writes `io_data_out` at the tail.
  - A write with count == `TX_DEPTH` is dropped and sets `io_ovf`. This holds even if a pop happens in the same cycle.
  - `io_ovf` clears only on reset.
- **TX pop:** a transfer occurs when `tx_valid && tx_ready`. `tx_data` is the head entry, presented combinationally from the FIFO storage.
- **Simultaneous push and pop** with 0 < count < `TX_DEPTH`: count is unchanged.
- **Pointers:** `log2(TX_DEPTH)` bits, wrapping naturally. Count is `log2(TX_DEPTH)+1` bits.
- **RX capture:** `rx_valid && rx_ready` loads `rx_buf` and sets `rx_full`. `rx_ready` = `!rx_full`.
- **Read FSM** (`R_IDLE`, `R_WAIT`, `R_DONE`):
  - `R_IDLE`: on `io_rden`, if `rx_full`, load `io_rdata` from `rx_buf`, clear `rx_full`, and go to `R_DONE`. Otherwise go to `R_WAIT`.
  - `R_WAIT`: when `rx_full`, load `io_rdata`, clear `rx_full`, and go to `R_DONE`.
  - `R_DONE`: go to `R_IDLE` unconditionally. `io_rden` is ignored in `R_WAIT` and `R_DONE`.
  - `io_rdata` holds its value until the next load.
- **`io_busy`** is registered. The next-state value is 1 when, after this cycle, count == `TX_DEPTH` or the FSM is in `R_WAIT`.
- **Concurrency:** read and write paths are independent, and both strobes may be high in the same cycle.

## Timing
- **Write:** strobe at edge N makes the FIFO entry visible, with `tx_valid` high, after edge N.
- **Read, `rx_full` already set:** strobe sampled at edge N gives `io_rdata` valid after N, and `io_busy` stays 0.
- **Read, RX empty:**
  - `io_busy` = 1 from edge N.
  - `rx_data` is captured at edge M.
  - `io_rdata` is loaded at edge M+1.
  - `io_busy` = 0 after M+1.
- **`io_busy` for a full FIFO** rises on the edge that makes count == `TX_DEPTH`, and falls on the edge of the pop that makes count < `TX_DEPTH`.

## Configuration
- **`IO_LOOPBACK_EN` undefined:** no `lb_mode` port, and operation is as described above.
- **`IO_LOOPBACK_EN` defined:** `lb_mode` port is present.
  - With `lb_mode` = 1, the FIFO head feeds the RX holding register in place of `rx_data`/`rx_valid`. A pop occurs when `tx_valid && !rx_full`.
  - External `tx_valid` is forced to 0 and `rx_ready` is forced to 0.
  - With `lb_mode` = 0, behaviour is identical to the undefined case.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle. Expect all outputs at their reset values immediately, and `rx_ready` = 1.
- **Write and drain:** write `0xABCD1234` then `0x00000001` with `tx_ready` = 0. Expect `tx_valid` = 1 and `tx_data` = `0xABCD1234`. Raise `tx_ready` and expect two pops in order, then `tx_valid` = 0.
- **Overflow:** with `tx_ready` = 0, write 5 words `0x10`..`0x14`.
  - Expect `io_busy` = 1 after the 4th write.
  - Expect the 5th write dropped and `io_ovf` = 1.
  - Draining yields `0x10`..`0x13` only.
- **Stalled read:** `io_rden` with RX empty gives `io_busy` = 1. Present `rx_data` = `0x87654321` with `rx_valid` = 1 two cycles later. Expect `io_rdata` = `0x87654321` one edge after capture, and `io_busy` = 0.
- **Fast read and concurrency:** preload RX with `0xDEADBEEF`, then pulse `io_rden` and `io_write_en` (`0x5A5A5A5A`) in the same cycle. Expect `io_rdata` = `0xDEADBEEF` next cycle with `io_busy` = 0, and the FIFO head = `0x5A5A5A5A`.
- **Loopback (`IO_LOOPBACK_EN`):** with `lb_mode` = 1, write `0x12345678` then read. Expect `io_rdata` = `0x12345678`, and external `tx_valid` = 0 throughout.
